// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared types and elaboration helpers for the
// segmented pipelined adder.
//   nstages(width, seg)   number of pipeline stages, ceil(width/seg)
//   seg_lo(k, seg)        LSB index of the segment added by stage k
//   seg_w(k, width, seg)  width of segment k (the last one may be narrower)
//   stage_ctrl_t          per-stage control record; the data part of each
//                         stage (partial sum, remaining a/b) is sized
//                         exactly per stage inside the top module.
//                         A subtract is folded into ~b and carry-in at
//                         stage 0, so no per-stage sub flag is needed.
package pipelined_adder_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int nstages(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction

  function automatic int seg_w(input int k, input int width, input int seg);
    int rem;
    rem = width - k * seg;
    return (rem < seg) ? rem : seg;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle of the pipelined adder.
//   a, b, cin, in_valid / in_ready    input side (producer -> adder)
//   sum, cout, ovf, out_valid / out_ready  output side (adder -> consumer)
//   sub  (only with PIPELINED_ADDER_SUB_EN) selects a-b, sampled with a/b
// modport slave is the adder side, master the producer/consumer side.
interface pipelined_adder_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;
`endif

  modport slave (
    input  a, b, cin, in_valid, out_ready,
`ifdef PIPELINED_ADDER_SUB_EN
    input  sub,
`endif
    output in_ready, sum, cout, ovf, out_valid
  );

  modport master (
    output a, b, cin, in_valid, out_ready,
`ifdef PIPELINED_ADDER_SUB_EN
    output sub,
`endif
    input  in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/pipelined_adder_seg.sv
// seg_adder: combinational W-bit ripple-carry adder used as one pipeline
// stage's segment.
//   a_i, b_i  segment operands      c_i     carry in
//   s_o       segment sum           c_o     carry out of bit W-1
//   cmsb_o    carry into bit W-1 (feeds signed overflow at the last stage)
module seg_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         cmsb_o
);

  always_comb begin
    logic c;
    c      = c_i;
    s_o    = '0;
    cmsb_o = c_i;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cmsb_o = c;
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    c_o = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into SEG-bit ripple segments, one
// segment per pipeline stage, carry handed across stages through registers.
// Valid/ready on both sides with full backpressure, 1 result per cycle,
// latency NSTAGES cycles when unstalled.
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         pipelined_adder_if.slave (a, b, cin, in_valid/in_ready,
//               sum, cout, ovf, out_valid/out_ready)
// Optional: PIPELINED_ADDER_SUB_EN adds bus.sub; sub=1 computes a-b
// (cin ignored, cout=1 means no borrow, ovf is the subtract overflow).
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int SEG   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_adder_if.slave   bus
);

  localparam int NS = nstages(WIDTH, SEG);

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
  // a - b == a + ~b + 1, so a subtract is just an add with inverted b
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  stage_ctrl_t [NS-1:0] ctrl_q;
  logic [NS-1:0]        go;     // stage k may load this cycle
  logic [NS-1:0]        vin;    // valid presented to stage k
  logic [NS-1:0]        cy_d;   // segment carry out of stage k
  logic                 ovf_d, ovf_q;

  // Ready chain from the output back: a stage loads when it is empty or
  // its successor takes its current item this cycle.
  always_comb begin
    logic g;
    go = '0;
    g  = bus.out_ready;
    for (int k = NS - 1; k >= 0; k--) begin
      g     = ~ctrl_q[k].valid | g;
      go[k] = g;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (go[k]) begin
          ctrl_q[k].valid <= vin[k];
          if (vin[k]) ctrl_q[k].carry <= cy_d[k];
        end
      end
      if (go[NS-1] && vin[NS-1]) ovf_q <= ovf_d;
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_st
    localparam int LO  = seg_lo(k, SEG);
    localparam int W   = seg_w(k, WIDTH, SEG);
    localparam int HI  = LO + W - 1;
    localparam int REM = WIDTH - 1 - HI;   // operand bits still to be added

    logic [W-1:0] sa, sb, ss;
    logic         ci, co, cm;
    logic [HI:0]  s_d, s_q;                // sum bits [HI:0] resolved so far

    if (k == 0) begin : g_src
      assign sa     = bus.a[HI:0];
      assign sb     = b_eff[HI:0];
      assign ci     = cin_eff;
      assign vin[k] = bus.in_valid;
      assign s_d    = ss;
    end else begin : g_src
      assign sa     = g_st[k-1].g_rem.ra_q[W-1:0];
      assign sb     = g_st[k-1].g_rem.rb_q[W-1:0];
      assign ci     = ctrl_q[k-1].carry;
      assign vin[k] = ctrl_q[k-1].valid;
      // lower sum bits ride along so the full result lines up at the end
      assign s_d    = {ss, g_st[k-1].s_q};
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] ra_d, rb_d, ra_q, rb_q;
      if (k == 0) begin : g_src
        assign ra_d = bus.a[WIDTH-1:HI+1];
        assign rb_d = b_eff[WIDTH-1:HI+1];
      end else begin : g_src
        assign ra_d = g_st[k-1].g_rem.ra_q[REM+W-1:W];
        assign rb_d = g_st[k-1].g_rem.rb_q[REM+W-1:W];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (go[k] && vin[k]) begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                s_q <= '0;
      else if (go[k] && vin[k])  s_q <= s_d;
    end

    seg_adder #(.W(W)) u_add (
      .a_i    (sa),
      .b_i    (sb),
      .c_i    (ci),
      .s_o    (ss),
      .c_o    (co),
      .cmsb_o (cm)
    );

    assign cy_d[k] = co;

    if (k == NS - 1) begin : g_ovf
      assign ovf_d = cm ^ co;
    end else begin : g_ovf
      // only the top segment's MSB carries matter for overflow
      logic unused_cm;
      assign unused_cm = cm;
    end
  end

  assign bus.sum       = g_st[NS-1].s_q;
  assign bus.cout      = ctrl_q[NS-1].carry;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = ctrl_q[NS-1].valid;
  assign bus.in_ready  = go[0];

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
  localparam int WIDTH = 24;
  localparam int SEG   = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus();

  pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  logic acc, drn, ovalid, have_exp;
  res_t obs, expv;

  // Reference: plain integer arithmetic on 25-bit values.
  function automatic res_t ref_model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                     logic cin, logic sub);
    res_t             r;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    logic             c;
    bb     = sub ? ~b : b;
    c      = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c);
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  task automatic set_in(logic v, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                        logic cin, logic sub);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    bus.sub      = sub;
`else
    if (sub) bus.cin = cin;
`endif
  endtask

  // One clock: observe at negedge, update the model queue, return at posedge+1.
  task automatic tick();
    logic sub_now;
    @(negedge clk);
`ifdef PIPELINED_ADDER_SUB_EN
    sub_now = bus.sub;
`else
    sub_now = 1'b0;
`endif
    acc      = bus.in_valid && bus.in_ready;
    drn      = bus.out_valid && bus.out_ready;
    ovalid   = bus.out_valid;
    obs      = '{sum: bus.sum, cout: bus.cout, ovf: bus.ovf};
    have_exp = 1'b0;
    if (acc) q.push_back(ref_model(bus.a, bus.b, bus.cin, sub_now));
    if (drn && q.size() > 0) begin
      expv     = q.pop_front();
      have_exp = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 24'hFFFFFF;
      2:       return 24'h7FFFFF;
      3:       return 24'h800000;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.sum !== 24'h0) begin errors++; $display("FAIL reset_sum: got %h want 000000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Sends one item, waits for it, checks latency and the given result.
  task automatic one_shot(string name, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                          logic cin, logic sub, res_t want);
    int   lat;
    logic got;
    bus.out_ready = 1'b1;
    set_in(1'b1, a, b, cin, sub);
    tick();
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept: got %b want 1", name, acc); end
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      lat++;
      if (drn) got = 1'b1;
    end
    checks++;
    if (!got || lat != 3) begin
      errors++; $display("FAIL %s_latency: got %0d (seen=%b) want 3", name, lat, got);
    end
    if (got) begin
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 name, obs.sum, obs.cout, obs.ovf, want.sum, want.cout, want.ovf);
      end
    end
  endtask

  task automatic test_directed();
    one_shot("carry_chain", 24'h00FFFF, 24'h000001, 1'b0, 1'b0, '{24'h010000, 1'b0, 1'b0});
    one_shot("wrap_cin",    24'hFFFFFF, 24'h000000, 1'b1, 1'b0, '{24'h000000, 1'b1, 1'b0});
    one_shot("pos_ovf",     24'h7FFFFF, 24'h000001, 1'b0, 1'b0, '{24'h800000, 1'b0, 1'b1});
    one_shot("neg_ovf",     24'h800000, 24'h800000, 1'b0, 1'b0, '{24'h000000, 1'b1, 1'b1});
    one_shot("plain",       24'h123456, 24'h654321, 1'b1, 1'b0, '{24'h777778, 1'b0, 1'b0});
  endtask

`ifdef PIPELINED_ADDER_SUB_EN
  task automatic test_sub();
    one_shot("sub_borrow", 24'h000005, 24'h000007, 1'b0, 1'b1, '{24'hFFFFFE, 1'b0, 1'b0});
    one_shot("sub_ovf",    24'h800000, 24'h000001, 1'b0, 1'b1, '{24'h7FFFFF, 1'b1, 1'b1});
  endtask
`endif

  task automatic test_backpressure();
    logic [WIDTH-1:0] ia[5], ib[5];
    int   idx, drained;
    logic have_first, gap;
    res_t first;
    for (int i = 0; i < 5; i++) begin ia[i] = WIDTH'($urandom); ib[i] = WIDTH'($urandom); end
    bus.out_ready = 1'b0;
    idx = 0; have_first = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_in(idx < 5, (idx < 5) ? ia[idx] : '0, (idx < 5) ? ib[idx] : '0, 1'b0, 1'b0);
      tick();
      if (acc) idx++;
      if (ovalid) begin
        if (!have_first) begin first = obs; have_first = 1'b1; end
        else begin
          checks++;
          if (obs !== first) begin errors++; $display("FAIL bp_stable: got sum=%h want sum=%h", obs.sum, first.sum); end
        end
      end
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL bp_accepts: got %0d want 3", idx); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (!have_first) begin errors++; $display("FAIL bp_out_valid: got 0 want 1"); end
    bus.out_ready = 1'b1;
    drained = 0; gap = 1'b0;
    for (int c = 0; c < 12 && drained < 5; c++) begin
      set_in(idx < 5, (idx < 5) ? ia[idx] : '0, (idx < 5) ? ib[idx] : '0, 1'b0, 1'b0);
      tick();
      if (acc) idx++;
      if (drn) begin
        checks++;
        if (!have_exp || obs !== expv) begin
          errors++; $display("FAIL bp_order: got sum=%h cout=%b want sum=%h cout=%b", obs.sum, obs.cout, expv.sum, expv.cout);
        end
        drained++;
      end else gap = 1'b1;
    end
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (drained != 5) begin errors++; $display("FAIL bp_drained: got %0d want 5", drained); end
    checks++; if (gap) begin errors++; $display("FAIL bp_no_gaps: got gap=1 want gap=0"); end
  endtask

  task automatic test_random();
    logic prev_stall;
    res_t prev_obs;
    int   n_acc, n_drn;
    prev_stall = 1'b0; n_acc = 0; n_drn = 0;
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom), 1'($urandom));
      bus.out_ready = $urandom_range(0, 2) != 0;
      tick();
      if (acc) n_acc++;
      if (prev_stall) begin
        checks++;
        if (!ovalid || obs !== prev_obs) begin
          errors++; $display("FAIL rnd_stall_hold: got v=%b sum=%h want v=1 sum=%h", ovalid, obs.sum, prev_obs.sum);
        end
      end
      if (drn) begin
        n_drn++;
        checks++;
        if (!have_exp || obs !== expv) begin
          errors++;
          $display("FAIL rnd_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   obs.sum, obs.cout, obs.ovf, expv.sum, expv.cout, expv.ovf);
        end
      end
      prev_stall = ovalid && !bus.out_ready;
      prev_obs   = obs;
    end
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (drn) begin
        n_drn++;
        checks++;
        if (!have_exp || obs !== expv) begin
          errors++; $display("FAIL rnd_drain: got sum=%h want sum=%h", obs.sum, expv.sum);
        end
      end
    end
    checks++; if (n_drn != n_acc) begin errors++; $display("FAIL rnd_count: got %0d results want %0d", n_drn, n_acc); end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    bus.out_ready = 1'b0;
    set_in(1'b1, 24'h111111, 24'h222222, 1'b0, 1'b0); tick();
    set_in(1'b1, 24'h333333, 24'h444444, 1'b0, 1'b0); tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin tick(); seen = ovalid; end
    checks++; if (!seen) begin errors++; $display("FAIL rst_fill: got out_valid=0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b want 1", bus.in_ready); end
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL rst_stale: got out_valid=%b want 0", ovalid); end
    end
    one_shot("rst_after", 24'hABCDEF, 24'h012345, 1'b1,  1'b0, ref_model(24'hABCDEF, 24'h012345, 1'b1, 1'b0));
  endtask

  initial begin
    bus.out_ready = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_directed();
`ifdef PIPELINED_ADDER_SUB_EN
    test_sub();
`endif
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
